vlsu_cam_prio_search: RTL and testbench

Multi-port content-addressable memory for the vector load/store unit. It holds DEPTH tagged entries with valid bits and serves READ independent masked searches per cycle. Each search returns the oldest matching entry relative to a circular head pointer, plus a multi-hit flag. It supersedes the single-priority CAM with per-entry invalidation, global flush, ternary search masks, rotating-priority selection and registered outputs.

---
 rtl/vlsu_cam_pkg.sv | 18 +
 rtl/vlsu_cam_prio_enc.sv | 54 +++++
 rtl/vlsu_cam_prio_search.sv | 124 ++++++++++++
 tb/tb_vlsu_cam_prio_search.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_cam_pkg.sv
// vlsu_cam_pkg: shared constants and helpers for the VLSU priority-search CAM.
//   CAM_WIDTH / CAM_DEPTH / CAM_WRITE / CAM_READ : default parameter values
//   CAM_MAX_DEPTH : largest hit vector the multi-hit helper accepts
//   multi_hit()   : 1 when at least two bits of the vector are set
package vlsu_cam_pkg;

    localparam int unsigned CAM_WIDTH     = 50;
    localparam int unsigned CAM_DEPTH     = 32;
    localparam int unsigned CAM_WRITE     = 1;
    localparam int unsigned CAM_READ      = 3;
    localparam int unsigned CAM_MAX_DEPTH = 1024;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic multi_hit(input logic [CAM_MAX_DEPTH-1:0] vec);
        return |(vec & (vec - {{(CAM_MAX_DEPTH-1){1'b0}}, 1'b1}));
    endfunction

endpackage

// File: rtl/vlsu_cam_prio_enc.sv
// vlsu_cam_prio_enc: combinational rotating-priority encoder.
//   hit   : per-entry hit vector
//   head  : priority origin (oldest entry)
//   index : first set bit at or above head, wrapping to the lowest set bit; 0 if none
//   found : any bit set
//   multi : two or more bits set
module vlsu_cam_prio_enc
    import vlsu_cam_pkg::*;
#(
    parameter  int unsigned DEPTH   = CAM_DEPTH,
    localparam int unsigned ADDRESS = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]   hit,
    input  logic [ADDRESS-1:0] head,
    output logic [ADDRESS-1:0] index,
    output logic               found,
    output logic               multi
);

    typedef logic [ADDRESS-1:0] addr_t;

    addr_t                    lo_idx;
    addr_t                    up_idx;
    logic                     up_found;
    logic [CAM_MAX_DEPTH-1:0] hit_ext;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        lo_idx   = '0;
        up_idx   = '0;
        up_found = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                lo_idx = addr_t'(i);
                if (i >= int'(head)) begin
                    up_idx   = addr_t'(i);
                    up_found = 1'b1;
                end
            end
        end
    end

    // Nothing at or above head means the search wrapped past DEPTH-1.
    assign index = up_found ? up_idx : lo_idx;
    assign found = |hit;

    always_comb begin
        hit_ext             = '0;
        hit_ext[DEPTH-1:0]  = hit;
    end

    assign multi = multi_hit(hit_ext);

endmodule

// File: rtl/vlsu_cam_prio_search.sv
// vlsu_cam_prio_search: multi-port ternary CAM with rotating-priority (oldest-first) search.
//   clk, arst_n           : clock, asynchronous active-low reset
//   flush_i               : invalidate every entry
//   head_i                : index of oldest entry, origin of the priority scan
//   enable_i[r][e]        : per-port, per-entry compare enable
//   write_i/_addr_i/_data_i : write ports (highest port wins on collisions)
//   clear_i/clear_addr_i  : invalidate one entry
//   read_i/_data_i/_mask_i  : search ports, mask bit 1 = compared
//   match_o/match_addr_o/match_multi_o : registered search results
//   valid_o               : current valid bits
module vlsu_cam_prio_search
    import vlsu_cam_pkg::*;
#(
    parameter  int unsigned WIDTH   = CAM_WIDTH,
    parameter  int unsigned DEPTH   = CAM_DEPTH,
    parameter  int unsigned WRITE   = CAM_WRITE,
    parameter  int unsigned READ    = CAM_READ,
    localparam int unsigned ADDRESS = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           flush_i,
    input  logic [ADDRESS-1:0]             head_i,
    input  logic [READ-1:0][DEPTH-1:0]     enable_i,
    input  logic [WRITE-1:0]               write_i,
    input  logic [WRITE-1:0][ADDRESS-1:0]  write_addr_i,
    input  logic [WRITE-1:0][WIDTH-1:0]    write_data_i,
    input  logic                           clear_i,
    input  logic [ADDRESS-1:0]             clear_addr_i,
    input  logic [READ-1:0]                read_i,
    input  logic [READ-1:0][WIDTH-1:0]     read_data_i,
    input  logic [READ-1:0][WIDTH-1:0]     read_mask_i,
    output logic [READ-1:0]                match_o,
    output logic [READ-1:0][ADDRESS-1:0]   match_addr_o,
    output logic [READ-1:0]                match_multi_o,
    output logic [DEPTH-1:0]               valid_o
);

    typedef logic [WIDTH-1:0]   width_t;
    typedef logic [ADDRESS-1:0] addr_t;
    typedef logic [DEPTH-1:0]   depth_t;

    width_t [DEPTH-1:0] data_q, data_d;
    depth_t             valid_q, valid_d;

    depth_t [READ-1:0]  hit;
    addr_t  [READ-1:0]  sel_idx;
    logic   [READ-1:0]  sel_found;
    logic   [READ-1:0]  sel_multi;

    logic   [READ-1:0]  match_q;
    addr_t  [READ-1:0]  match_addr_q;
    logic   [READ-1:0]  match_multi_q;

    // Apply lowest precedence first: clear, then writes in port order, then flush.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear_i && (32'(clear_addr_i) < DEPTH)) begin
            valid_d[clear_addr_i] = 1'b0;
        end
        for (int w = 0; w < int'(WRITE); w++) begin
            if (write_i[w] && (32'(write_addr_i[w]) < DEPTH)) begin
                data_d[write_addr_i[w]]  = write_data_i[w];
                valid_d[write_addr_i[w]] = 1'b1;
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Compare against pre-edge storage; an idle port yields an all-zero hit vector,
    // which makes its registered results zero without extra gating.
    always_comb begin
        hit = '0;
        for (int r = 0; r < int'(READ); r++) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                hit[r][e] = read_i[r] & valid_q[e] & enable_i[r][e] &
                            ~|((data_q[e] ^ read_data_i[r]) & read_mask_i[r]);
            end
        end
    end

    for (genvar r = 0; r < READ; r++) begin : g_enc
        vlsu_cam_prio_enc #(
            .DEPTH (DEPTH)
        ) u_enc (
            .hit   (hit[r]),
            .head  (head_i),
            .index (sel_idx[r]),
            .found (sel_found[r]),
            .multi (sel_multi[r])
        );
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            match_q       <= '0;
            match_addr_q  <= '0;
            match_multi_q <= '0;
        end else begin
            match_q       <= sel_found;
            match_addr_q  <= sel_idx;
            match_multi_q <= sel_multi;
        end
    end

    assign match_o       = match_q;
    assign match_addr_o  = match_addr_q;
    assign match_multi_o = match_multi_q;
    assign valid_o       = valid_q;

endmodule

// File: tb/tb_vlsu_cam_prio_search.sv
// tb_vlsu_cam_prio_search: directed self-checking bench for vlsu_cam_prio_search
// (two write ports, three search ports, 32 entries of 50 bits).
module tb_vlsu_cam_prio_search;

    localparam int unsigned W  = 50;
    localparam int unsigned D  = 32;
    localparam int unsigned WR = 2;
    localparam int unsigned RD = 3;
    localparam int unsigned A  = 5;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic                    clk = 1'b0;
    logic                    arst_n;
    logic                    flush_i;
    logic [A-1:0]            head_i;
    logic [RD-1:0][D-1:0]    enable_i;
    logic [WR-1:0]           write_i;
    logic [WR-1:0][A-1:0]    write_addr_i;
    logic [WR-1:0][W-1:0]    write_data_i;
    logic                    clear_i;
    logic [A-1:0]            clear_addr_i;
    logic [RD-1:0]           read_i;
    logic [RD-1:0][W-1:0]    read_data_i;
    logic [RD-1:0][W-1:0]    read_mask_i;
    logic [RD-1:0]           match_o;
    logic [RD-1:0][A-1:0]    match_addr_o;
    logic [RD-1:0]           match_multi_o;
    logic [D-1:0]            valid_o;

    int tests;
    int failed;

    always #5 clk = ~clk;

    vlsu_cam_prio_search #(
        .WIDTH (W),
        .DEPTH (D),
        .WRITE (WR),
        .READ  (RD)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .flush_i       (flush_i),
        .head_i        (head_i),
        .enable_i      (enable_i),
        .write_i       (write_i),
        .write_addr_i  (write_addr_i),
        .write_data_i  (write_data_i),
        .clear_i       (clear_i),
        .clear_addr_i  (clear_addr_i),
        .read_i        (read_i),
        .read_data_i   (read_data_i),
        .read_mask_i   (read_mask_i),
        .match_o       (match_o),
        .match_addr_o  (match_addr_o),
        .match_multi_o (match_multi_o),
        .valid_o       (valid_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        flush_i      = 1'b0;
        write_i      = '0;
        write_addr_i = '0;
        write_data_i = '0;
        clear_i      = 1'b0;
        clear_addr_i = '0;
        read_i       = '0;
        read_data_i  = '0;
        read_mask_i  = '1;
        enable_i     = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int addr, input logic [W-1:0] d);
        write_i[p]      = 1'b1;
        write_addr_i[p] = A'(addr);
        write_data_i[p] = d;
    endtask

    task automatic srch(input int p, input logic [W-1:0] key, input logic [W-1:0] mask);
        read_i[p]      = 1'b1;
        read_data_i[p] = key;
        read_mask_i[p] = mask;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        arst_n = 1'b0;
        head_i = '0;
        quiet();

        #2;
        check("rst_valid", 64'(valid_o), 64'h0);
        check("rst_match", 64'(match_o), 64'h0);
        check("rst_addr", 64'(match_addr_o), 64'h0);
        #10 arst_n = 1'b1;

        // Fill every entry j with j+1.
        for (int j = 0; j < int'(D); j++) begin
            wr(0, j, W'(j + 1));
            tick();
            quiet();
        end
        check("fill_valid", 64'(valid_o), 64'hffff_ffff);

        head_i = 5'd0;
        srch(0, W'(32), ONES);
        srch(1, W'(0), ONES);
        srch(2, W'(5), ONES);
        tick();
        quiet();
        check("basic_match", 64'(match_o), 64'b101);
        check("basic_addr0", 64'(match_addr_o[0]), 64'd31);
        check("basic_addr1", 64'(match_addr_o[1]), 64'd0);
        check("basic_addr2", 64'(match_addr_o[2]), 64'd4);
        check("basic_multi", 64'(match_multi_o), 64'b000);

        // Data 7 at entries 3 and 20; move entry 6 (originally 7) out of the way.
        wr(0, 3, W'(7));
        wr(1, 20, W'(7));
        tick();
        quiet();
        wr(0, 6, W'(100));
        tick();
        quiet();

        head_i = 5'd10;
        srch(0, W'(7), ONES);
        enable_i[0][20] = 1'b0;
        srch(1, W'(7), ONES);
        tick();
        quiet();
        check("prio_en_addr", 64'(match_addr_o[0]), 64'd3);
        check("prio_en_multi", 64'(match_multi_o[0]), 64'd0);
        check("prio_h10_addr", 64'(match_addr_o[1]), 64'd20);
        check("prio_h10_multi", 64'(match_multi_o[1]), 64'd1);
        check("prio_idle_port", 64'({match_o[2], match_addr_o[2], match_multi_o[2]}), 64'd0);

        head_i = 5'd2;
        srch(0, W'(7), ONES);
        tick();
        quiet();
        check("prio_h2_addr", 64'(match_addr_o[0]), 64'd3);
        check("prio_h2_multi", 64'(match_multi_o[0]), 64'd1);

        // Ternary masks: mask 0 hits everything; bit-0 mask hits odd data.
        head_i = 5'd17;
        srch(0, W'(0), W'(0));
        srch(2, W'(1), W'(1));
        tick();
        quiet();
        check("mask0_match", 64'(match_o[0]), 64'd1);
        check("mask0_addr", 64'(match_addr_o[0]), 64'd17);
        check("mask0_multi", 64'(match_multi_o[0]), 64'd1);
        check("mask1_h17_addr", 64'(match_addr_o[2]), 64'd18);

        head_i = 5'd0;
        srch(1, W'(1), W'(1));
        tick();
        quiet();
        check("mask1_h0_addr", 64'(match_addr_o[1]), 64'd0);
        check("mask1_h0_multi", 64'(match_multi_o[1]), 64'd1);

        // Clear entry 4 (data 5).
        clear_i      = 1'b1;
        clear_addr_i = 5'd4;
        tick();
        quiet();
        check("clear_valid4", 64'(valid_o[4]), 64'd0);
        srch(0, W'(5), ONES);
        tick();
        quiet();
        check("clear_miss", 64'(match_o[0]), 64'd0);

        // Write beats clear on the same entry.
        wr(0, 4, W'(5));
        clear_i      = 1'b1;
        clear_addr_i = 5'd4;
        tick();
        quiet();
        check("wr_clr_valid4", 64'(valid_o[4]), 64'd1);
        srch(0, W'(5), ONES);
        tick();
        quiet();
        check("wr_clr_match", 64'(match_o[0]), 64'd1);
        check("wr_clr_addr", 64'(match_addr_o[0]), 64'd4);

        // No bypass: same-cycle write is invisible to the search.
        wr(0, 9, W'(99));
        srch(0, W'(99), ONES);
        tick();
        quiet();
        check("nobypass_miss", 64'(match_o[0]), 64'd0);
        srch(0, W'(99), ONES);
        tick();
        quiet();
        check("after_wr_match", 64'(match_o[0]), 64'd1);
        check("after_wr_addr", 64'(match_addr_o[0]), 64'd9);

        // Two write ports on entry 2: port 1 wins.
        wr(0, 2, W'(11));
        wr(1, 2, W'(22));
        tick();
        quiet();
        srch(0, W'(22), ONES);
        srch(1, W'(11), ONES);
        tick();
        quiet();
        check("wcoll_hi_match", 64'(match_o[0]), 64'd1);
        check("wcoll_hi_addr", 64'(match_addr_o[0]), 64'd2);
        check("wcoll_lo_addr", 64'(match_addr_o[1]), 64'd10);
        check("wcoll_lo_multi", 64'(match_multi_o[1]), 64'd0);

        // Flush with a concurrent search: the search sees pre-flush state.
        flush_i = 1'b1;
        srch(0, W'(22), ONES);
        tick();
        quiet();
        check("flush_presearch", 64'(match_o[0]), 64'd1);
        check("flush_valid", 64'(valid_o), 64'h0);
        srch(0, W'(0), W'(0));
        srch(1, W'(22), ONES);
        tick();
        quiet();
        check("flush_miss", 64'(match_o), 64'd0);

        // Async reset while searches are active.
        wr(0, 5, W'(1));
        tick();
        quiet();
        srch(0, W'(0), W'(0));
        srch(1, W'(0), W'(0));
        srch(2, W'(0), W'(0));
        tick();
        check("pre_rst_match", 64'(match_o), 64'b111);
        check("pre_rst_addr", 64'(match_addr_o), 64'({5'd5, 5'd5, 5'd5}));
        #2 arst_n = 1'b0;
        #1;
        check("arst_match", 64'(match_o), 64'd0);
        check("arst_addr", 64'(match_addr_o), 64'd0);
        check("arst_multi", 64'(match_multi_o), 64'd0);
        check("arst_valid", 64'(valid_o), 64'd0);
        #3 arst_n = 1'b1;
        tick();
        check("post_rst_miss", 64'(match_o), 64'd0);
        check("post_rst_valid", 64'(valid_o), 64'd0);
        quiet();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
